// File: rtl/enc_cnt_axis_packer.sv
// enc_cnt_axis_packer: packs counter results into numbered 32-bit AXI-Stream words with frames and run trailers
module enc_cnt_axis_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm,
    input  logic [23:0]                   cnt,
    input  logic                          ready,
    input  logic                          overflow,
    output logic                          m_axis_tvalid,
    output logic [31:0]                   m_axis_tdata,
    output logic [3:0]                    m_axis_tstrb,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          drop,
    output logic [15:0]                   drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_MAX  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] LVL_SAMP = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [5:0]  FL_LAST  = 6'(FRAME_LEN - 1);

    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   mc;
    logic          arm_q, trl_pend;
    logic [5:0]    seq, frame_idx;
    logic [15:0]   drop_snap, drop_next;
    logic          rise, fall, samp_req, samp_push, trl_push, push, pop, out_free, mem_rd, mem_wr, w_last;
    logic [31:0]   w_data;

    assign m_axis_tstrb = 4'hF;
    assign level = mc + {{AW{1'b0}}, m_axis_tvalid};

    always_comb begin
        rise      = arm & ~arm_q;
        fall      = ~arm & arm_q;
        samp_req  = ready & arm_q;
        samp_push = samp_req & ~trl_pend & (level < LVL_SAMP);
        trl_push  = trl_pend & ~samp_push & (level < LVL_MAX);
        push      = samp_push | trl_push;
        w_last    = trl_push | (frame_idx == FL_LAST);
        w_data    = trl_push ? {2'b10, seq, 8'h00, drop_snap} : {1'b0, overflow, seq, cnt};
        drop_next = (samp_req & ~samp_push & (drop_cnt != 16'hFFFF)) ? drop_cnt + 16'd1 : drop_cnt;
        pop       = m_axis_tvalid & m_axis_tready;
        out_free  = ~m_axis_tvalid | pop;
        mem_rd    = out_free & (mc != '0);
        mem_wr    = push & ~(out_free & (mc == '0));
    end

    always_ff @(posedge clk)
        if (mem_wr) mem[wr_ptr] <= {w_last, w_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q         <= 1'b0;
            trl_pend      <= 1'b0;
            seq           <= '0;
            frame_idx     <= '0;
            drop_cnt      <= '0;
            drop          <= 1'b0;
            drop_snap     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mc            <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            arm_q     <= arm;
            drop_cnt  <= rise ? 16'd0 : drop_next;
            drop      <= rise ? 1'b0 : drop | (samp_req & ~samp_push);
            if (fall) begin
                trl_pend  <= 1'b1;
                drop_snap <= drop_next;
            end else if (trl_push) trl_pend <= 1'b0;
            seq       <= rise ? 6'd0 : push ? seq + 6'd1 : seq;
            frame_idx <= (rise | trl_push | (samp_push & w_last)) ? 6'd0 : samp_push ? frame_idx + 6'd1 : frame_idx;
            if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
            mc <= mc + {{AW{1'b0}}, mem_wr} - {{AW{1'b0}}, mem_rd};
            if (out_free) begin
                if (mc != '0) begin
                    {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
                    m_axis_tvalid <= 1'b1;
                end else if (push) begin
                    {m_axis_tlast, m_axis_tdata} <= {w_last, w_data};
                    m_axis_tvalid <= 1'b1;
                end else m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_enc_cnt_axis_packer.sv
// tb_enc_cnt_axis_packer: directed checks of packing, framing, drops, trailers and reset
module tb_enc_cnt_axis_packer;
    logic        clk = 1'b0;
    logic        rst, arm, ready, overflow, m_axis_tready;
    logic [23:0] cnt;
    logic        m_axis_tvalid, m_axis_tlast, drop;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tstrb;
    logic [4:0]  level;
    logic [15:0] drop_cnt;
    logic [32:0] q[$];
    int tests = 0, fails = 0;

    enc_cnt_axis_packer #(.FIFO_DEPTH(16), .FRAME_LEN(8)) dut (
        .clk(clk), .rst(rst), .arm(arm), .cnt(cnt), .ready(ready), .overflow(overflow),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .level(level), .drop(drop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && m_axis_tvalid && m_axis_tready) q.push_back({m_axis_tlast, m_axis_tdata});

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [23:0] c, input logic ov);
        ready = 1'b1; cnt = c; overflow = ov;
        tick();
        ready = 1'b0; overflow = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] sw(input int s, input int c, input logic l);
        return {l, 2'b00, 6'(s), 24'(c)};
    endfunction

    initial begin
        rst = 1'b1; arm = 1'b0; ready = 1'b0; cnt = '0; overflow = 1'b0; m_axis_tready = 1'b1;
        tick(2);
        chk("rst_tvalid", 33'(m_axis_tvalid), 33'd0);
        chk("rst_tdata", 33'(m_axis_tdata), 33'd0);
        chk("rst_tlast", 33'(m_axis_tlast), 33'd0);
        chk("rst_tstrb", 33'(m_axis_tstrb), 33'hF);
        chk("rst_level", 33'(level), 33'd0);
        chk("rst_drop", 33'(drop), 33'd0);
        chk("rst_drop_cnt", 33'(drop_cnt), 33'd0);
        rst = 1'b0;
        tick();
        // T1: basic numbering and one-cycle latency
        arm = 1'b1; tick(); q.delete();
        pulse(24'd5, 1'b0);
        chk("t1_latency_tvalid", 33'(m_axis_tvalid), 33'd1);
        chk("t1_latency_tdata", 33'(m_axis_tdata), 33'h5);
        pulse(24'd9, 1'b0);
        pulse(24'd12, 1'b0);
        arm = 1'b0; tick(6);
        chk("t1_count", 33'(q.size()), 33'd4);
        chk("t1_w0", q[0], {1'b0, 32'h00000005});
        chk("t1_w1", q[1], {1'b0, 32'h01000009});
        chk("t1_w2", q[2], {1'b0, 32'h0200000C});
        chk("t1_trailer", q[3], {1'b1, 32'h83000000});
        // T2: 17 samples, frames of 8, trailer seq 17
        q.delete(); arm = 1'b1; tick();
        ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cnt = 24'(100 + i);
            tick();
        end
        ready = 1'b0; arm = 1'b0;
        tick(6);
        chk("t2_count", 33'(q.size()), 33'd18);
        for (int i = 0; i < 17; i++)
            chk($sformatf("t2_w%0d", i), q[i], sw(i, 100 + i, (i == 7) || (i == 15)));
        chk("t2_trailer", q[17], {1'b1, 32'h91000000});
        // T3: overflow flag
        q.delete(); arm = 1'b1; tick();
        pulse(24'hFFFFFF, 1'b1);
        arm = 1'b0; tick(5);
        chk("t3_word", q[0], {1'b0, 32'h40FFFFFF});
        chk("t3_trailer", q[1], {1'b1, 32'h81000000});
        chk("t3_drop", 33'(drop), 33'd0);
        // T4: backpressure, drops, reserved trailer slot
        q.delete(); m_axis_tready = 1'b0; arm = 1'b1; tick();
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cnt = 24'(i);
            tick();
        end
        ready = 1'b0;
        chk("t4_level15", 33'(level), 33'd15);
        chk("t4_drop_cnt", 33'(drop_cnt), 33'd5);
        chk("t4_drop", 33'(drop), 33'd1);
        chk("t4_head_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h0});
        arm = 1'b0; tick(2);
        chk("t4_level16", 33'(level), 33'd16);
        chk("t4_drop_sticky", 33'(drop), 33'd1);
        m_axis_tready = 1'b1; tick(20);
        chk("t4_count", 33'(q.size()), 33'd16);
        for (int i = 0; i < 15; i++)
            chk($sformatf("t4_w%0d", i), q[i], sw(i, i, i == 7));
        chk("t4_trailer", q[15], {1'b1, 32'h8F000005});
        chk("t4_level_empty", 33'(level), 33'd0);
        // T5: sample in fall cycle kept, one cycle later ignored
        q.delete(); arm = 1'b1; tick(2);
        ready = 1'b1; cnt = 24'h77; arm = 1'b0;
        tick();
        cnt = 24'h88;
        tick();
        ready = 1'b0;
        tick(4);
        chk("t5_count", 33'(q.size()), 33'd2);
        chk("t5_sample", q[0], {1'b0, 32'h00000077});
        chk("t5_trailer", q[1], {1'b1, 32'h81000000});
        chk("t5_drop_cnt", 33'(drop_cnt), 33'd0);
        // T6: reset with queued words
        m_axis_tready = 1'b0; arm = 1'b1; tick();
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cnt = 24'(16 + i);
            tick();
        end
        ready = 1'b0;
        chk("t6_level6", 33'(level), 33'd6);
        chk("t6_tvalid", 33'(m_axis_tvalid), 33'd1);
        rst = 1'b1; tick();
        chk("t6_rst_tvalid", 33'(m_axis_tvalid), 33'd0);
        chk("t6_rst_level", 33'(level), 33'd0);
        rst = 1'b0; m_axis_tready = 1'b1; q.delete();
        tick(2);
        pulse(24'h33, 1'b0);
        tick(3);
        chk("t6_count", 33'(q.size()), 33'd1);
        chk("t6_seq0", q[0], {1'b0, 32'h00000033});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
